// File: rtl/apb_uart_master.sv
// apb_uart_master: APB initiator that configures a UART slave and then polls it,
// bridging valid/ready byte streams to the UART TX/RX data registers.
module apb_uart_master #(
  parameter logic [12:0] BAUD_VALUE = 13'd0,
  parameter bit          BIT8       = 1'b1,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          ODD_N_EVEN = 1'b0,
  parameter bit          FRCTN_EN   = 1'b0,
  parameter logic [2:0]  BAUD_FRCTN = 3'd0,
  parameter int          POLL_GAP   = 4
) (
  input  logic       PCLK,
  input  logic       PRESET,
  output logic [4:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [3:0] err_flags,
  input  logic       err_clr,
  output logic       init_done
);
  typedef enum logic [2:0] {INIT_BAUD, INIT_CTRL, INIT_FRAC, POLL, DECIDE, RX_RD, TX_WR, GAP} state_t;
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;
  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);
  state_t     state_q, state_d;
  phase_t     phase_q, phase_d;
  logic [7:0] gap_q, gap_d;
  logic [1:0] status_q, status_d;
  logic       tx_full_q, tx_full_d;
  logic [7:0] tx_hold_q, tx_hold_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [3:0] err_q, err_d;
  logic       init_done_q, init_done_d;
  logic       xfer_st, done, rx_go, tx_go, poll_done;
  assign xfer_st   = state_q inside {INIT_BAUD, INIT_CTRL, INIT_FRAC, POLL, RX_RD, TX_WR};
  assign done      = phase_q == PH_ACCESS && PREADY;
  assign poll_done = state_q == POLL && done;
  assign rx_go     = status_q[1] && !rx_valid_q;
  assign tx_go     = status_q[0] && tx_full_q;
  assign tx_ready  = init_done_q && !tx_full_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign err_flags = err_q;
  assign init_done = init_done_q;
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= INIT_BAUD;
      phase_q     <= PH_IDLE;
      gap_q       <= '0;
      status_q    <= '0;
      tx_full_q   <= 1'b0;
      tx_hold_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      err_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      gap_q       <= gap_d;
      status_q    <= status_d;
      tx_full_q   <= tx_full_d;
      tx_hold_q   <= tx_hold_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
    end
  end
  // Every access state walks idle -> setup -> access, so each transfer is followed by a bus-idle cycle.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    phase_d = !xfer_st ? PH_IDLE : phase_q == PH_IDLE ? PH_SETUP : phase_q == PH_SETUP ? PH_ACCESS :
              done ? PH_IDLE : PH_ACCESS;
    case (state_q)
      INIT_BAUD: state_d = done ? INIT_CTRL : state_q;
      INIT_CTRL: state_d = done ? (FRCTN_EN ? INIT_FRAC : POLL) : state_q;
      INIT_FRAC: state_d = done ? POLL : state_q;
      POLL:      state_d = done ? DECIDE : state_q;
      DECIDE: begin
        state_d = rx_go ? RX_RD : tx_go ? TX_WR : POLL_GAP == 0 ? POLL : GAP;
        gap_d   = '0;
      end
      RX_RD, TX_WR: state_d = done ? POLL : state_q;
      GAP: begin
        gap_d   = gap_q + 8'd1;
        state_d = gap_q == GAP_LAST ? POLL : GAP;
      end
      default: state_d = INIT_BAUD;
    endcase
  end
  always_comb begin
    PSEL    = xfer_st && phase_q != PH_IDLE;
    PENABLE = PSEL && phase_q == PH_ACCESS;
    PWRITE  = PSEL && state_q inside {INIT_BAUD, INIT_CTRL, INIT_FRAC, TX_WR};
    PADDR   = !PSEL ? 5'h00 : state_q == INIT_BAUD ? 5'h08 : state_q == INIT_CTRL ? 5'h0C :
              state_q == INIT_FRAC ? 5'h14 : state_q == POLL ? 5'h10 : state_q == RX_RD ? 5'h04 : 5'h00;
    PWDATA  = !PWRITE ? 8'h00 : state_q == INIT_BAUD ? BAUD_VALUE[7:0] :
              state_q == INIT_CTRL ? {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8} :
              state_q == INIT_FRAC ? {5'd0, BAUD_FRCTN} : tx_hold_q;
  end
  // A failed TX write still frees the holding register; the byte is dropped.
  always_comb begin
    tx_full_d   = (tx_valid && tx_ready) ? 1'b1 : (state_q == TX_WR && done) ? 1'b0 : tx_full_q;
    tx_hold_d   = (tx_valid && tx_ready) ? tx_data : tx_hold_q;
    rx_valid_d  = (state_q == RX_RD && done) ? 1'b1 : (rx_valid_q && rx_ready) ? 1'b0 : rx_valid_q;
    rx_data_d   = (state_q == RX_RD && done) ? PRDATA : rx_data_q;
    status_d    = poll_done ? PRDATA[1:0] : status_q;
    err_d       = (err_clr ? 4'd0 : err_q) | {done && PSLVERR, poll_done ? PRDATA[4:2] : 3'd0};
    init_done_d = init_done_q | (done && (state_q == INIT_FRAC || (state_q == INIT_CTRL && !FRCTN_EN)));
  end
endmodule
